// File: rtl/dff_bank_pkg.sv
// Package for the flip-flop bank with sequenced clear/preset sweep.
// Contents:
//   op_e     - per-channel operation code (HOLD/LOAD/TOGGLE/SHIFT)
//   state_e  - sweep sequencer states (IDLE/SWEEP/DONE)
//   op_next  - next-value decode for one channel register, computed at
//              MAX_W bits; callers truncate to their own width
// Optional build macro honoured by the bundle: QBAR_OUT_EN (adds qb port).
package dff_bank_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'd0,
        OP_LOAD   = 2'd1,
        OP_TOGGLE = 2'd2,
        OP_SHIFT  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Next register value for an accepted op. SHIFT brings sin in at the LSB;
    // bits above the caller's width are discarded by the caller.
    function automatic logic [MAX_W-1:0] op_next(
        input op_e              op,
        input logic [MAX_W-1:0] cur,
        input logic [MAX_W-1:0] di,
        input logic             sin
    );
        logic [MAX_W-1:0] nxt;
        nxt = cur;
        case (op)
            OP_HOLD:   nxt = cur;
            OP_LOAD:   nxt = di;
            OP_TOGGLE: nxt = cur ^ di;
            OP_SHIFT:  nxt = {cur[MAX_W-2:0], sin};
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/dff_bank_sweep_if.sv
// Bus interface for dff_bank_sweep.
// Signals: req/op/ch_sel/di/sin (op request), sweep_start/sweep_kind (sweep
// request), q/ack/err/busy/done (status), qb (only when QBAR_OUT_EN is defined).
// Modports: master (stimulus side), slave (the register bank).
interface dff_bank_sweep_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic                      req;
    logic [1:0]                op;
    logic [SEL_W-1:0]          ch_sel;
    logic [WIDTH-1:0]          di;
    logic                      sin;
    logic                      sweep_start;
    logic                      sweep_kind;
    logic [CHANNELS*WIDTH-1:0] q;
    logic                      ack;
    logic                      err;
    logic                      busy;
    logic                      done;
`ifdef QBAR_OUT_EN
    logic [CHANNELS*WIDTH-1:0] qb;
`endif

    modport master (
        output req, op, ch_sel, di, sin, sweep_start, sweep_kind,
        input  q, ack, err, busy, done
`ifdef QBAR_OUT_EN
        , input qb
`endif
    );

    modport slave (
        input  req, op, ch_sel, di, sin, sweep_start, sweep_kind,
        output q, ack, err, busy, done
`ifdef QBAR_OUT_EN
        , output qb
`endif
    );

endinterface

// File: rtl/dff_bank_cell.sv
// One WIDTH-bit channel register of the bank.
// Ports: clk, clr_n (async active-low clear), we (op write enable), op, di,
//        sin (serial in for SHIFT), sweep_we/sweep_kind (sweep force to
//        zero or PRESET_VAL, takes priority over we), q (register value).
module dff_bank_cell
    import dff_bank_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             we,
    input  op_e              op,
    input  logic [WIDTH-1:0] di,
    input  logic             sin,
    input  logic             sweep_we,
    input  logic             sweep_kind,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_s;

    // Next-value select: sweep force, then accepted op, else hold.
    always_comb begin
        next_s = q_r;
        if (sweep_we) begin
            if (sweep_kind) begin
                next_s = PRESET_VAL;
            end else begin
                next_s = {WIDTH{1'b0}};
            end
        end else if (we) begin
            next_s = WIDTH'(op_next(op, MAX_W'(q_r), MAX_W'(di), sin));
        end else begin
            next_s = q_r;
        end
    end

    // Channel storage with asynchronous clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_r <= {WIDTH{1'b0}};
        end else begin
            q_r <= next_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/dff_bank_sweep.sv
// Multi-channel flip-flop register bank with per-channel LOAD/TOGGLE/SHIFT
// ops and a sequenced clear/preset sweep that visits one channel per clock.
// Ports: clk, clr_n (async active-low reset), bus (dff_bank_sweep_if.slave):
//   req/op/ch_sel/di/sin  op request, accepted only in IDLE without sweep_start
//   sweep_start/kind      sweep request, accepted in IDLE (wins over req)
//   q                     channel k at q[k*WIDTH +: WIDTH]
//   ack/err               1-cycle pulses after an accepted op (err: bad ch_sel)
//   busy/done             sweep in progress / final sweep cycle
// Build macro QBAR_OUT_EN: when defined, bus.qb carries ~q.
module dff_bank_sweep
    import dff_bank_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter int               CHANNELS   = 4,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic              clk,
    input  logic              clr_n,
    dff_bank_sweep_if.slave   bus
);

    localparam int                SEL_W    = $clog2(CHANNELS);
    localparam int                QW       = CHANNELS * WIDTH;
    localparam logic [SEL_W:0]    CH_LIMIT = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(CHANNELS - 1);

    state_e            state_r;
    state_e            state_next_s;
    logic [SEL_W-1:0]  idx_r;
    logic [SEL_W-1:0]  idx_next_s;
    logic              kind_r;
    logic              ack_r;
    logic              err_r;
    logic              sweep_go_s;
    logic              op_go_s;
    logic              sel_ok_s;
    logic [QW-1:0]     q_s;

    // Sweep request beats an op request issued in the same cycle.
    assign sweep_go_s = (state_r == ST_IDLE) && bus.sweep_start;
    assign op_go_s    = (state_r == ST_IDLE) && bus.req && !bus.sweep_start;
    assign sel_ok_s   = ({1'b0, bus.ch_sel} < CH_LIMIT);

    // Sequencer next state and sweep index.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                idx_next_s = {SEL_W{1'b0}};
                if (bus.sweep_start) begin
                    state_next_s = ST_SWEEP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (idx_r == LAST_IDX) begin
                    state_next_s = ST_DONE;
                    idx_next_s   = idx_r;
                end else begin
                    state_next_s = ST_SWEEP;
                    idx_next_s   = idx_r + SEL_W'(1);
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
                idx_next_s   = {SEL_W{1'b0}};
            end
            default: begin
                state_next_s = ST_IDLE;
                idx_next_s   = {SEL_W{1'b0}};
            end
        endcase
    end

    // Sequencer state, index, captured sweep kind and op handshake pulses.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= ST_IDLE;
            idx_r   <= {SEL_W{1'b0}};
            kind_r  <= 1'b0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            // Kind is held for the whole sweep so the input may change freely.
            if (sweep_go_s) begin
                kind_r <= bus.sweep_kind;
            end else begin
                kind_r <= kind_r;
            end
            ack_r <= op_go_s;
            err_r <= op_go_s && !sel_ok_s;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic we_s;
        logic sweep_we_s;

        assign we_s       = op_go_s && sel_ok_s && (bus.ch_sel == SEL_W'(k));
        assign sweep_we_s = (state_r == ST_SWEEP) && (idx_r == SEL_W'(k));

        dff_bank_cell #(
            .WIDTH      (WIDTH),
            .PRESET_VAL (PRESET_VAL)
        ) u_cell (
            .clk        (clk),
            .clr_n      (clr_n),
            .we         (we_s),
            .op         (op_e'(bus.op)),
            .di         (bus.di),
            .sin        (bus.sin),
            .sweep_we   (sweep_we_s),
            .sweep_kind (kind_r),
            .q          (q_s[k*WIDTH +: WIDTH])
        );
    end

    assign bus.q    = q_s;
    assign bus.ack  = ack_r;
    assign bus.err  = err_r;
    assign bus.busy = (state_r != ST_IDLE);
    assign bus.done = (state_r == ST_DONE);
`ifdef QBAR_OUT_EN
    assign bus.qb   = ~q_s;
`endif

endmodule

// File: tb/tb_dff_bank_sweep.sv
// Self-checking bench for dff_bank_sweep: directed steps plus a randomized
// phase against a behavioural model (channel array + sweep cycle counter).
// A second instance with CHANNELS=3 exercises the out-of-range ch_sel path.
// Honours QBAR_OUT_EN (checks qb == ~q when defined).
module tb_dff_bank_sweep;

    logic clk = 1'b0;
    logic clr_n;

    always #5 clk = ~clk;

    dff_bank_sweep_if #(.WIDTH(4), .CHANNELS(4)) bus4 ();
    dff_bank_sweep_if #(.WIDTH(4), .CHANNELS(3)) bus3 ();

    dff_bank_sweep #(.WIDTH(4), .CHANNELS(4), .PRESET_VAL(4'hF)) u_dut4 (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus4)
    );

    dff_bank_sweep #(.WIDTH(4), .CHANNELS(3), .PRESET_VAL(4'hF)) u_dut3 (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus3)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model of the 4-channel instance.
    logic [3:0] mq [4];
    bit         sw_act;
    int         sw_t;
    bit         sw_kind;
    bit         m_ack;
    bit         m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) mq[k] = 4'h0;
        sw_act = 1'b0; sw_t = 0; sw_kind = 1'b0; m_ack = 1'b0; m_err = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        int c;
        int v;
        m_ack = 1'b0;
        m_err = 1'b0;
        if (sw_act) begin
            sw_t++;
            if (sw_t <= 4) mq[sw_t-1] = sw_kind ? 4'hF : 4'h0;
            if (sw_t == 5) sw_act = 1'b0;
        end else if (bus4.sweep_start) begin
            sw_act = 1'b1; sw_t = 0; sw_kind = bus4.sweep_kind;
        end else if (bus4.req) begin
            m_ack = 1'b1;
            c = int'(bus4.ch_sel);
            if (c >= 4) begin
                m_err = 1'b1;
            end else begin
                v = int'(mq[c]);
                case (int'(bus4.op))
                    1: v = int'(bus4.di);
                    2: v = v ^ int'(bus4.di);
                    3: v = (v * 2 + int'(bus4.sin)) % 16;
                    default: v = v;
                endcase
                mq[c] = 4'(v);
            end
        end
    endtask

    task automatic check_all(input string ph);
        logic [15:0] eq;
        for (int k = 0; k < 4; k++) eq[k*4 +: 4] = mq[k];
        chk({ph, "_q"},    64'(bus4.q),    64'(eq));
        chk({ph, "_ack"},  64'(bus4.ack),  64'(m_ack));
        chk({ph, "_err"},  64'(bus4.err),  64'(m_err));
        chk({ph, "_busy"}, 64'(bus4.busy), 64'(sw_act));
        chk({ph, "_done"}, 64'(sw_act && sw_t == 4 ? 1'b1 : 1'b0), 64'(bus4.done));
`ifdef QBAR_OUT_EN
        chk({ph, "_qb"},   64'(bus4.qb),   64'(~eq));
`endif
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input bit r, input int o, input int c, input int d, input bit s);
        bus4.req = r; bus4.op = 2'(o); bus4.ch_sel = 2'(c); bus4.di = 4'(d); bus4.sin = s;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;

        clr_n = 1'b0;
        set_op(1'b0, 0, 0, 0, 1'b0);
        bus4.sweep_start = 1'b0; bus4.sweep_kind = 1'b0;
        bus3.req = 1'b0; bus3.op = 2'd0; bus3.ch_sel = 2'd0; bus3.di = 4'h0;
        bus3.sin = 1'b0; bus3.sweep_start = 1'b0; bus3.sweep_kind = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;

        // Reset state.
        check_all("reset");
        chk("reset_q3", 64'(bus3.q), 64'(12'h000));

        // LOAD ch2 = A, then ack must drop after one cycle.
        set_op(1'b1, 1, 2, 4'hA, 1'b0);
        tick();
        check_all("load");
        chk("load_nib2", 64'(bus4.q[11:8]), 64'(4'hA));
        chk("load_ack", 64'(bus4.ack), 64'(1'b1));
        set_op(1'b0, 0, 0, 0, 1'b0);
        tick();
        check_all("load_idle");

        // TOGGLE ch2 with F, then SHIFT ch2 with sin=1.
        set_op(1'b1, 2, 2, 4'hF, 1'b0);
        tick();
        chk("toggle_nib2", 64'(bus4.q[11:8]), 64'(4'h5));
        check_all("toggle");
        set_op(1'b1, 3, 2, 0, 1'b1);
        tick();
        chk("shift_nib2", 64'(bus4.q[11:8]), 64'(4'hB));
        check_all("shift");

        // Preset sweep; a req held during busy must never be acked.
        set_op(1'b0, 0, 0, 0, 1'b0);
        bus4.sweep_start = 1'b1; bus4.sweep_kind = 1'b1;
        tick();
        check_all("sw_acc");
        busy_cnt = int'(bus4.busy);
        done_cnt = int'(bus4.done);
        bus4.sweep_start = 1'b0; bus4.sweep_kind = 1'b0;
        set_op(1'b1, 1, 0, 4'h3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("sweep");
            chk("sweep_noack", 64'(bus4.ack), 64'(1'b0));
            if (i < 4) chk("sweep_nib", 64'(bus4.q[i*4 +: 4]), 64'(4'hF));
            busy_cnt += int'(bus4.busy);
            done_cnt += int'(bus4.done);
        end
        chk("busy_cycles", 64'(busy_cnt), 64'(5));
        chk("done_pulses", 64'(done_cnt), 64'(1));
        set_op(1'b0, 0, 0, 0, 1'b0);
        tick();
        check_all("post_sweep");

        // Clear sweep aborted by reset at idx=2.
        bus4.sweep_start = 1'b1; bus4.sweep_kind = 1'b0;
        tick();
        bus4.sweep_start = 1'b0;
        tick();
        tick();
        check_all("clr_mid");
        chk("clr_mid_nib2", 64'(bus4.q[11:8]), 64'(4'hF));
        #2 clr_n = 1'b0;
        #1;
        model_reset();
        chk("abort_q", 64'(bus4.q), 64'(16'h0000));
        chk("abort_busy", 64'(bus4.busy), 64'(1'b0));
        chk("abort_done", 64'(bus4.done), 64'(1'b0));
        @(negedge clk);
        clr_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_all("abort_after");
            done_cnt += int'(bus4.done);
        end
        chk("abort_no_done", 64'(done_cnt), 64'(0));
        set_op(1'b1, 1, 1, 4'h6, 1'b0);
        tick();
        chk("abort_new_ack", 64'(bus4.ack), 64'(1'b1));
        check_all("abort_new");

        // Out-of-range channel on the 3-channel instance.
        set_op(1'b0, 0, 0, 0, 1'b0);
        bus3.req = 1'b1; bus3.op = 2'd1; bus3.ch_sel = 2'd1; bus3.di = 4'h5;
        tick();
        chk("c3_ack", 64'(bus3.ack), 64'(1'b1));
        chk("c3_err0", 64'(bus3.err), 64'(1'b0));
        chk("c3_q", 64'(bus3.q), 64'(12'h050));
        bus3.ch_sel = 2'd3; bus3.di = 4'h7;
        tick();
        chk("c3_bad_ack", 64'(bus3.ack), 64'(1'b1));
        chk("c3_bad_err", 64'(bus3.err), 64'(1'b1));
        chk("c3_bad_q", 64'(bus3.q), 64'(12'h050));
        bus3.req = 1'b0;
        tick();
        chk("c3_idle_ack", 64'(bus3.ack), 64'(1'b0));
        chk("c3_idle_err", 64'(bus3.err), 64'(1'b0));

        // Randomized phase against the model.
        for (int i = 0; i < 400; i++) begin
            set_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)));
            bus4.sweep_start = ($urandom_range(0, 15) == 0);
            bus4.sweep_kind  = 1'($urandom_range(0, 1));
            tick();
            check_all("rand");
        end

        // Asynchronous reset between clocks mid-run.
        #2 clr_n = 1'b0;
        #1;
        model_reset();
        chk("mid_reset_q", 64'(bus4.q), 64'(16'h0000));
        chk("mid_reset_ack", 64'(bus4.ack), 64'(1'b0));
        chk("mid_reset_err", 64'(bus4.err), 64'(1'b0));
        chk("mid_reset_busy", 64'(bus4.busy), 64'(1'b0));
        chk("mid_reset_done", 64'(bus4.done), 64'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
